// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer
//   Queues Modified victim lines evicted by the L1 and drains them, one per
//   handshake, onto the L2 write port. Non-Modified victims are accepted and
//   discarded. A snoop port reports whether a snooped line is still pending.
//
//   Optional feature macro: WB_STATS_EN
//     defined   -> wb_count / drop_count are saturating event counters
//     undefined -> both outputs tied to zero, no counter registers
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     evict_valid/ready    victim handshake (evict_line, evict_set payload)
//     l2_wr_valid/ready    write-back handshake (l2_wr_addr payload)
//     snoop_valid/addr     snoop lookup, snoop_hit result (combinational)
//     occupancy            number of pending write-backs
//     wb_count/drop_count  statistics
//
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   The producer holds valid and payload stable until the transfer; ready
//   never depends combinationally on the matching valid.

package l2_wb_pkg;
  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef struct packed {
    logic [11:0] tag;
    mesi_t       mesi_bits;
    logic [1:0]  lru;
  } cache_line_t;
endpackage

module l2_writeback_buffer
  import l2_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       evict_valid,
  input  cache_line_t                evict_line,
  input  logic [13:0]                evict_set,
  output logic                       evict_ready,
  output logic                       l2_wr_valid,
  output logic [31:0]                l2_wr_addr,
  input  logic                       l2_wr_ready,
  input  logic                       snoop_valid,
  input  logic [31:0]                snoop_addr,
  output logic                       snoop_hit,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           wb_count,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  // Each entry stores the line address without offset: {tag, set}.
  logic [25:0]      line_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic full, accept, enq, deq, match_any;

  // Offset bits of the snoop address and the LRU field carry no information here.
  logic unused_bits;
  assign unused_bits = ^{evict_line.lru, snoop_addr[5:0]};

  assign full        = (occ_q == OCC_W'(DEPTH));
  assign evict_ready = !full;
  assign l2_wr_valid = (occ_q != '0);
  assign accept      = evict_valid && evict_ready;
  assign enq         = accept && (evict_line.mesi_bits == MESI_M);
  assign deq         = l2_wr_valid && l2_wr_ready;
  assign occupancy   = occ_q;
  assign l2_wr_addr  = l2_wr_valid ? {line_q[head_q], 6'b0} : 32'h0;

  // Valid bits are registered, so an entry written this cycle is not yet
  // visible while the entry being drained this cycle still is.
  always_comb begin
    match_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (line_q[i] == snoop_addr[31:6])) match_any = 1'b1;
    end
  end
  assign snoop_hit = snoop_valid && match_any;

  always_comb begin
    occ_d = occ_q;
    case ({enq, deq})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Enqueue only happens when not full and dequeue only when not empty, so
  // head and tail never address the same slot in a cycle doing both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (enq) begin
        line_q[tail_q] <= {evict_line.tag, evict_set};
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      occ_q <= occ_d;
    end
  end

`ifdef WB_STATS_EN
  logic [CNT_W-1:0] wb_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (enq && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + CNT_W'(1);
      if (accept && !enq && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign wb_count   = wb_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign wb_count   = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_l2_writeback_buffer.sv
module tb_l2_writeback_buffer;
  import l2_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef WB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              evict_valid = 1'b0;
  cache_line_t       evict_line = '0;
  logic [13:0]       evict_set = '0;
  logic              evict_ready;
  logic              l2_wr_valid;
  logic [31:0]       l2_wr_addr;
  logic              l2_wr_ready = 1'b0;
  logic              snoop_valid = 1'b0;
  logic [31:0]       snoop_addr = '0;
  logic              snoop_hit;
  logic [2:0]        occupancy;
  logic [CNT_W-1:0]  wb_count;
  logic [CNT_W-1:0]  drop_count;

  l2_writeback_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_valid(evict_valid), .evict_line(evict_line), .evict_set(evict_set),
    .evict_ready(evict_ready),
    .l2_wr_valid(l2_wr_valid), .l2_wr_addr(l2_wr_addr), .l2_wr_ready(l2_wr_ready),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_hit(snoop_hit),
    .occupancy(occupancy), .wb_count(wb_count), .drop_count(drop_count)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_evict(input logic [11:0] tag, input mesi_t mesi, input logic [13:0] set);
    evict_valid = 1'b1;
    evict_line  = '{tag: tag, mesi_bits: mesi, lru: 2'b01};
    evict_set   = set;
  endtask

  task automatic idle_evict();
    evict_valid = 1'b0;
    evict_line  = '0;
    evict_set   = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (occupancy !== 3'd0) $display("FAIL rst_occ got %0d exp 0", occupancy); else passed++;
    total++; if (evict_ready !== 1'b1) $display("FAIL rst_evict_ready got %b exp 1", evict_ready); else passed++;
    total++; if (l2_wr_valid !== 1'b0) $display("FAIL rst_l2_valid got %b exp 0", l2_wr_valid); else passed++;
    total++; if (l2_wr_addr !== 32'h0) $display("FAIL rst_l2_addr got %h exp 0", l2_wr_addr); else passed++;
    total++; if (snoop_hit !== 1'b0) $display("FAIL rst_snoop got %b exp 0", snoop_hit); else passed++;
    total++; if (wb_count !== '0) $display("FAIL rst_wb_count got %0d exp 0", wb_count); else passed++;
    total++; if (drop_count !== '0) $display("FAIL rst_drop_count got %0d exp 0", drop_count); else passed++;
    rst_n = 1'b1;
    tick(); tick();
    total++; if (l2_wr_valid !== 1'b0 || occupancy !== 3'd0 || evict_ready !== 1'b1)
      $display("FAIL idle_after_rst got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", l2_wr_valid, occupancy, evict_ready);
    else passed++;
  endtask

  task automatic test_single_m();
    l2_wr_ready = 1'b0;
    drive_evict(12'hABC, MESI_M, 14'h0010);
    settle();
    total++; if (l2_wr_valid !== 1'b0) $display("FAIL no_bypass got %b exp 0", l2_wr_valid); else passed++;
    tick();
    idle_evict();
    for (int i = 0; i < 5; i++) begin
      settle();
      total++; if (l2_wr_valid !== 1'b1) $display("FAIL hold_valid[%0d] got %b exp 1", i, l2_wr_valid); else passed++;
      total++; if (l2_wr_addr !== 32'hABC00400) $display("FAIL hold_addr[%0d] got %h exp ABC00400", i, l2_wr_addr); else passed++;
      tick();
    end
    total++; if (occupancy !== 3'd1) $display("FAIL single_occ got %0d exp 1", occupancy); else passed++;
    snoop_valid = 1'b1;
    snoop_addr  = 32'hABC0041F;
    settle();
    total++; if (snoop_hit !== 1'b1) $display("FAIL snoop_hit_offset got %b exp 1", snoop_hit); else passed++;
    snoop_addr = 32'hABC00440;
    settle();
    total++; if (snoop_hit !== 1'b0) $display("FAIL snoop_miss_set got %b exp 0", snoop_hit); else passed++;
    snoop_valid = 1'b0;
    snoop_addr  = 32'hABC00400;
    settle();
    total++; if (snoop_hit !== 1'b0) $display("FAIL snoop_not_valid got %b exp 0", snoop_hit); else passed++;
    // Drain cycle: entry still counts as pending.
    snoop_valid = 1'b1;
    l2_wr_ready = 1'b1;
    settle();
    total++; if (snoop_hit !== 1'b1) $display("FAIL snoop_drain_cycle got %b exp 1", snoop_hit); else passed++;
    tick();
    l2_wr_ready = 1'b0;
    settle();
    total++; if (snoop_hit !== 1'b0) $display("FAIL snoop_after_drain got %b exp 0", snoop_hit); else passed++;
    total++; if (occupancy !== 3'd0) $display("FAIL drained_occ got %0d exp 0", occupancy); else passed++;
    total++; if (l2_wr_valid !== 1'b0) $display("FAIL drained_valid got %b exp 0", l2_wr_valid); else passed++;
    total++; if (wb_count !== (STATS ? 16'd1 : 16'd0)) $display("FAIL wb_count_1 got %0d exp %0d", wb_count, STATS ? 1 : 0); else passed++;
    snoop_valid = 1'b0;
  endtask

  task automatic test_drop();
    drive_evict(12'h123, MESI_S, 14'h0001);
    tick();
    drive_evict(12'h456, MESI_E, 14'h0002);
    tick();
    idle_evict();
    settle();
    total++; if (occupancy !== 3'd0) $display("FAIL drop_occ got %0d exp 0", occupancy); else passed++;
    total++; if (l2_wr_valid !== 1'b0) $display("FAIL drop_valid got %b exp 0", l2_wr_valid); else passed++;
    total++; if (drop_count !== (STATS ? 16'd2 : 16'd0)) $display("FAIL drop_count_2 got %0d exp %0d", drop_count, STATS ? 2 : 0); else passed++;
    total++; if (wb_count !== (STATS ? 16'd1 : 16'd0)) $display("FAIL drop_wb_count got %0d exp %0d", wb_count, STATS ? 1 : 0); else passed++;
  endtask

  // Eight M victims through a 4-entry buffer: fill with L2 stalled, hold the
  // fifth while full, then alternate L2 ready so the pointers wrap.
  task automatic test_fill_wrap();
    int pushed = 0;
    int occ_exp = 0;
    int c = 0;
    bit do_push, do_pop;
    logic [11:0] tag;
    logic [13:0] set;
    exp_q.delete();
    while ((pushed < 8 || exp_q.size() != 0) && c < 80) begin
      if (pushed < 8) begin
        tag = 12'h100 + 12'(pushed);
        set = 14'(pushed * 3);
        drive_evict(tag, MESI_M, set);
        snoop_valid = 1'b1;
        snoop_addr  = {tag, set, 6'h00};
      end else begin
        idle_evict();
        snoop_valid = 1'b0;
      end
      l2_wr_ready = (c >= 6) ? c[0] : 1'b0;
      settle();
      total++; if (occupancy !== 3'(occ_exp)) $display("FAIL wrap_occ[c%0d] got %0d exp %0d", c, occupancy, occ_exp); else passed++;
      total++; if (evict_ready !== (occ_exp != DEPTH)) $display("FAIL wrap_ready[c%0d] got %b exp %b", c, evict_ready, occ_exp != DEPTH); else passed++;
      total++; if (l2_wr_valid !== (occ_exp != 0)) $display("FAIL wrap_valid[c%0d] got %b exp %b", c, l2_wr_valid, occ_exp != 0); else passed++;
      if (evict_valid) begin
        total++; if (snoop_hit !== 1'b0) $display("FAIL wrap_snoop_new[c%0d] got %b exp 0", c, snoop_hit); else passed++;
      end
      do_pop  = l2_wr_ready && (occ_exp != 0);
      do_push = evict_valid && (occ_exp != DEPTH);
      if (do_pop) begin
        total++; if (l2_wr_addr !== exp_q[0]) $display("FAIL wrap_addr[c%0d] got %h exp %h", c, l2_wr_addr, exp_q[0]); else passed++;
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        exp_q.push_back({tag, set, 6'h00});
        pushed++;
      end
      occ_exp = occ_exp + int'(do_push) - int'(do_pop);
      tick();
      c++;
    end
    idle_evict();
    snoop_valid = 1'b0;
    l2_wr_ready = 1'b0;
    total++; if (c >= 80) $display("FAIL wrap_timeout got %0d cycles exp <80", c); else passed++;
    settle();
    total++; if (occupancy !== 3'd0) $display("FAIL wrap_end_occ got %0d exp 0", occupancy); else passed++;
    total++; if (wb_count !== (STATS ? 16'd9 : 16'd0)) $display("FAIL wb_count_9 got %0d exp %0d", wb_count, STATS ? 9 : 0); else passed++;
  endtask

  task automatic test_reset_mid();
    l2_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_evict(12'h200 + 12'(i), MESI_M, 14'h0020 + 14'(i));
      tick();
    end
    idle_evict();
    settle();
    total++; if (occupancy !== 3'd3) $display("FAIL mid_pre_occ got %0d exp 3", occupancy); else passed++;
    l2_wr_ready = 1'b1;
    rst_n = 1'b0;
    settle();
    total++; if (l2_wr_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", l2_wr_valid); else passed++;
    total++; if (occupancy !== 3'd0) $display("FAIL mid_rst_occ got %0d exp 0", occupancy); else passed++;
    total++; if (l2_wr_addr !== 32'h0) $display("FAIL mid_rst_addr got %h exp 0", l2_wr_addr); else passed++;
    total++; if (evict_ready !== 1'b1) $display("FAIL mid_rst_ready got %b exp 1", evict_ready); else passed++;
    total++; if (wb_count !== '0 || drop_count !== '0) $display("FAIL mid_rst_cnt got %0d/%0d exp 0/0", wb_count, drop_count); else passed++;
    tick();
    l2_wr_ready = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    total++; if (l2_wr_valid !== 1'b0) $display("FAIL post_rst_stale_valid got %b exp 0", l2_wr_valid); else passed++;
    snoop_valid = 1'b1;
    snoop_addr  = {12'h200, 14'h0020, 6'h00};
    settle();
    total++; if (snoop_hit !== 1'b0) $display("FAIL post_rst_snoop got %b exp 0", snoop_hit); else passed++;
    snoop_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_m();
    test_drop();
    test_fill_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
